// File: rtl/imm_decode_pipe.sv
// Immediate decoder feeding a 2-entry skid FIFO of {imm_ext, imm_illegal}.
// Latency: 1 cycle from an accepted instruction to out_valid on an empty buffer.
// Backpressure: in_ready = (count < 2) from registered state only; out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset (async, active-high), flush (sync clear of buffered entries)
//   in_valid / in_ready / instr[24:0] (instruction bits 31:7) / imm_src[2:0]   upstream side
//   out_valid / out_ready / imm_ext[XLEN-1:0] / imm_illegal                    downstream side (head entry)
module imm_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_illegal
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH != 2) begin : g_bad_depth
        $error("imm_decode_pipe: DEPTH must be 2");
    end

    // ------------------------------------------------------------------
    // Immediate decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_d;
    logic            ill_d;

    always_comb begin
        // Sign-extending formats start from a fill of the sign bit and
        // overwrite the low bits; zero-extending formats start from zero.
        imm_d = {XLEN{instr[24]}};
        ill_d = 1'b0;
        case (imm_src)
            3'b000: imm_d[11:0] = instr[24:13];
            3'b001: imm_d[11:0] = {instr[24:18], instr[4:0]};
            3'b101: imm_d[12:0] = {instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            // U: on XLEN=64 the fill above sign-extends from bit 31 (= instr[24]).
            3'b010: imm_d[31:0] = {instr[24:5], 12'b0};
            3'b110: imm_d[20:0] = {instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            3'b011: begin
                imm_d      = '0;
                imm_d[4:0] = instr[12:8];
            end
            3'b100: begin
                imm_d = '0;
                if (XLEN == 64) imm_d[5:0] = instr[18:13];
                else            imm_d[4:0] = instr[17:13];
            end
            default: begin
                imm_d = '0;
                ill_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_mem_q [2];
    logic            ill_mem_q [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            // Flush wins over a same-cycle push/pop; the pushed entry is dropped.
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the output mux hides it whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem_q[wr_ptr_q] <= imm_d;
            ill_mem_q[wr_ptr_q] <= ill_d;
        end
    end

    assign imm_ext     = out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign imm_illegal = out_valid ? ill_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_imm_decode_pipe.sv
module tb_imm_decode_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, ill_a;
    logic [24:0] instr_a;
    logic [2:0]  src_a;
    logic [31:0] imm_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, ill_b;
    logic [24:0] instr_b;
    logic [2:0]  src_b;
    logic [63:0] imm_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc = 0;
    bit   stream_chk = 0;
    bit   arm_pop = 0;
    int   armed_pop_cyc = 0;

    imm_decode_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .instr(instr_a), .imm_src(src_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .imm_ext(imm_a), .imm_illegal(ill_a)
    );

    imm_decode_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr_b), .imm_src(src_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .imm_ext(imm_b), .imm_illegal(ill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare the head entry on every pop against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_output: got %h expected no entry", imm_a);
                end else begin
                    ea = q_a.pop_front();
                    chk("a_imm", {32'b0, imm_a}, {32'b0, ea.imm[31:0]});
                    chk("a_ill", {63'b0, ill_a}, {63'b0, ea.ill});
                end
                if (arm_pop) begin
                    armed_pop_cyc = cyc;
                    arm_pop = 0;
                end
            end
            if (!out_valid_a) chk("a_empty_shows_zero", {31'b0, ill_a, imm_a}, 64'd0);
            if (stream_chk) chk("a_stream_count1", {62'b0, out_valid_a, in_ready_a}, 64'd3);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_output: got %h expected no entry", imm_b);
                end else begin
                    eb = q_b.pop_front();
                    chk("b_imm", imm_b, eb.imm);
                    chk("b_ill", {63'b0, ill_b}, {63'b0, eb.ill});
                end
            end
            if (!out_valid_b) chk("b_empty_shows_zero", imm_b | {63'b0, ill_b}, 64'd0);
        end
    end

    // Offer one instruction; the expected result is queued on the cycle it is accepted.
    task automatic send(input bit b, input logic [24:0] ins, input logic [2:0] src,
                        input logic [63:0] eimm, input logic eill, output int acc_cyc);
        int   n = 0;
        bit   done = 0;
        exp_t e;
        e.imm   = eimm;
        e.ill   = eill;
        acc_cyc = -1;
        if (b) begin in_valid_b = 1'b1; instr_b = ins; src_b = src; end
        else   begin in_valid_a = 1'b1; instr_a = ins; src_a = src; end
        while (!done && n < 50) begin
            @(negedge clk);
            if ((b ? in_ready_b : in_ready_a) && !flush) begin
                if (b) q_b.push_back(e);
                else   q_a.push_back(e);
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (b) in_valid_b = 1'b0;
        else   in_valid_a = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready low for %0d cycles expected acceptance", n);
        end
    endtask

    // I-format helper: instr = k<<13 yields immediate k.
    task automatic si(input int k);
        int d;
        send(1'b0, 25'(k << 13), 3'b000, 64'(k), 1'b0, d);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d entries left expected 0/0", q_a.size(), q_b.size());
        end
        #1;
    endtask

    logic [24:0] ta_ins [11] = '{25'h1FFE001, 25'h000001F, 25'h1FC0000, 25'h0000001, 25'h100001E,
                                 25'h1000001, 25'h0002000, 25'h1001FE0, 25'h1FFFFFF, 25'h1FFFFFF,
                                 25'h1FFFFFF};
    logic [2:0]  ta_src [11] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd5, 3'd2, 3'd6, 3'd6, 3'd3, 3'd4, 3'd7};
    logic [31:0] ta_imm [11] = '{32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFFE0, 32'h00000800, 32'hFFFFF01E,
                                 32'h80000000, 32'h00000800, 32'hFFFFF000, 32'h0000001F, 32'h0000001F,
                                 32'h00000000};
    logic        ta_ill [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic [24:0] tb_ins [7] = '{25'h1000001, 25'h0001F00, 25'h1FFFFFF, 25'h1FFE001, 25'h0FFFFE0,
                                25'h100001E, 25'h1FFFFFF};
    logic [2:0]  tb_src [7] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd2, 3'd5, 3'd7};
    logic [63:0] tb_imm [7] = '{64'hFFFFFFFF80000000, 64'h000000000000001F, 64'h000000000000003F,
                                64'hFFFFFFFFFFFFFFFF, 64'h000000007FFFF000, 64'hFFFFFFFFFFFFF01E,
                                64'h0};
    logic        tb_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid_a = 1'b0; instr_a = '0; src_a = '0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; instr_b = '0; src_b = '0; out_ready_b = 1'b0;

        // Reset state, checked before the first clock edge.
        #2;
        chk("rst_out_valid_a", {63'b0, out_valid_a}, 64'd0);
        chk("rst_in_ready_a",  {63'b0, in_ready_a},  64'd1);
        chk("rst_imm_a",       {31'b0, ill_a, imm_a}, 64'd0);
        chk("rst_out_valid_b", {63'b0, out_valid_b}, 64'd0);
        chk("rst_in_ready_b",  {63'b0, in_ready_b},  64'd1);
        chk("rst_imm_b",       imm_b | {63'b0, ill_b}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Format table, XLEN=32, with first-entry latency check.
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        send(1'b0, ta_ins[0], ta_src[0], {32'b0, ta_imm[0]}, ta_ill[0], acc);
        @(negedge clk);
        chk("a_latency_1", {63'b0, out_valid_a}, 64'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 11; i++)
            send(1'b0, ta_ins[i], ta_src[i], {32'b0, ta_imm[i]}, ta_ill[i], acc);
        // Format table, XLEN=64.
        for (int i = 0; i < 7; i++)
            send(1'b1, tb_ins[i], tb_src[i], tb_imm[i], tb_ill[i], acc);
        drain();

        // Fill to two, hold a third, release: third accepted the cycle after the first pop.
        out_ready_a = 1'b0;
        si(1);
        si(2);
        @(negedge clk);
        chk("a_full_in_ready", {63'b0, in_ready_a}, 64'd0);
        chk("a_full_out_valid", {63'b0, out_valid_a}, 64'd1);
        @(posedge clk); #1;
        arm_pop = 1;
        fork
            send(1'b0, 25'(3 << 13), 3'b000, 64'd3, 1'b0, acc);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready_a = 1'b1;
            end
        join
        chk("a_third_after_pop", 64'(acc), 64'(armed_pop_cyc + 1));
        drain();

        // Steady state at count=1 with push and pop every cycle.
        out_ready_a = 1'b0;
        si(10);
        out_ready_a = 1'b1;
        stream_chk = 1;
        for (int i = 0; i < 10; i++) si(11 + i);
        stream_chk = 0;
        drain();

        // Flush at count=2 with a pending push.
        out_ready_a = 1'b0;
        si(50);
        si(51);
        flush = 1'b1; in_valid_a = 1'b1; instr_a = 25'(52 << 13); src_a = 3'b000;
        @(posedge clk);
        #1 flush = 1'b0; in_valid_a = 1'b0;
        q_a.delete();
        @(negedge clk);
        chk("flush2_out_valid", {63'b0, out_valid_a}, 64'd0);
        chk("flush2_in_ready",  {63'b0, in_ready_a},  64'd1);
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Flush beats an accepted push at count=1.
        out_ready_a = 1'b0;
        si(60);
        flush = 1'b1; in_valid_a = 1'b1; instr_a = 25'(61 << 13); src_a = 3'b000;
        @(posedge clk);
        #1 flush = 1'b0; in_valid_a = 1'b0;
        q_a.delete();
        @(negedge clk);
        chk("flush1_out_valid", {63'b0, out_valid_a}, 64'd0);
        out_ready_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset between edges with count=2.
        out_ready_a = 1'b0;
        si(70);
        si(71);
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", {63'b0, out_valid_a}, 64'd0);
        chk("arst_in_ready",  {63'b0, in_ready_a},  64'd1);
        chk("arst_imm",       {31'b0, ill_a, imm_a}, 64'd0);
        q_a.delete();
        #2 reset = 1'b0;
        @(posedge clk); #1;
        out_ready_a = 1'b1;
        si(72);
        @(negedge clk);
        chk("post_rst_latency", {63'b0, out_valid_a}, 64'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001: Parameter XLEN, default 32, datapath width; legal values are 32 and 64, and any other value SHALL fail elaboration.
REQ-002: Parameter DEPTH, fixed at 2, output buffer entries; the value SHALL be fixed at 2 (skid buffer).
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: flush  input  1  synchronous clear of all buffered entries.
REQ-006: in_valid  input  1  upstream offers an instruction this cycle.
REQ-007: in_ready  output  1  block accepts an instruction this cycle.
REQ-008: instr  input  25  instruction bits [31:7] (instr[0] = instruction bit 7).
REQ-009: imm_src  input  3  immediate format select.
REQ-010: out_valid  output  1  head entry valid.
REQ-011: out_ready  input  1  downstream consumes head entry this cycle.
REQ-012: imm_ext  output  XLEN  extended immediate of head entry.
REQ-013: imm_illegal  output  1  head entry used an unsupported imm_src.

Function
REQ-014: Formats SHALL be: 000 I {instr[24:13]} sign-ext; 001 S {instr[24:18],instr[4:0]} sign-ext; 101 B {instr[24],instr[0],instr[23:18],instr[4:1],0} sign-ext; 010 U {instr[24:5],12'b0}; 110 J {instr[24],instr[12:5],instr[13],instr[23:14],0} sign-ext.
REQ-015: New format 011 Z (CSR uimm) SHALL yield instr[12:8] zero-extended to XLEN.
REQ-016: New format 100 SH (shift amount) SHALL yield instr[18:13] zero-extended when XLEN=64 and instr[17:13] zero-extended when XLEN=32.
REQ-017: For XLEN=64, the U result SHALL be sign-extended from bit 31; for XLEN=32, it SHALL be unmodified.
REQ-018: imm_src 111 SHALL store imm_ext=0 with imm_illegal=1; all other codes SHALL store imm_illegal=0.
REQ-019: All sign extension SHALL replicate instr[24] up to bit XLEN-1.
REQ-020: A transfer SHALL occur on a cycle with in_valid&&in_ready; the computed immediate and flag are then written into a 2-entry FIFO.
REQ-021: in_ready SHALL equal (count<2), driven from registered state only, with no combinational path from out_ready.
REQ-022: out_valid SHALL equal (count>0), and imm_ext/imm_illegal SHALL present the head entry, or zero when empty.
REQ-023: Latency SHALL be 1 cycle: an entry accepted into an empty buffer at edge N SHALL make out_valid high after edge N.
REQ-024: A pop SHALL occur on a cycle with out_valid&&out_ready.
REQ-025: Simultaneous push and pop with count=1 SHALL leave count at 1, with the new entry becoming head after the pop.
REQ-026: Pop with count=2 SHALL make in_ready high the following cycle; no push SHALL occur in that same cycle.
REQ-027: Read/write pointers SHALL wrap modulo 2, and count SHALL never exceed 2 or underflow below 0.
REQ-028: flush SHALL set count=0 and pointers=0 at the next edge, taking priority over a simultaneous push or pop (the pushed entry is discarded).
REQ-029: With in_valid=0, no state other than pops/flush SHALL change.

Reset
REQ-030: While reset=1, count=0, pointers=0, out_valid=0, imm_ext=0, imm_illegal=0, and in_ready=1 SHALL hold, independent of clk.
REQ-031: Reset asserted mid-transfer SHALL discard all buffered entries, and the first accepted entry after deassertion SHALL obey REQ-023.
REQ-032: Storage array contents need not be reset, but they SHALL never be visible while out_valid=0.

Verification
REQ-033: Scenario: XLEN=32, instr=0x1FFE001 (addi x1,x0,-1), imm_src=000, out_ready=1 -> next cycle out_valid=1, imm_ext=0xFFFFFFFF, imm_illegal=0.
REQ-034: Scenario: XLEN=64, instr=0x1000001 (lui 0x80000), imm_src=010 -> imm_ext=0xFFFFFFFF80000000; with imm_src=011, instr[12:8]=0x1F -> imm_ext=0x1F.
REQ-035: Scenario: out_ready=0, three back-to-back in_valid pushes -> in_ready=0 after the 2nd accept, 3rd held; raise out_ready -> entries emerge in order, 3rd accepted the cycle after the first pop.
REQ-036: Scenario: count=1 with simultaneous push and pop for 10 cycles -> out_valid stays 1, count stays 1, and values stream in order with 1-cycle latency.
REQ-037: Scenario: count=2 with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed push never appears.
REQ-038: Scenario: imm_src=111 -> imm_ext=0, imm_illegal=1; async reset pulse between edges with count=2 -> out_valid=0 immediately, without waiting for clk.
